montgomery_exp: RTL and testbench

- Modular-exponentiation controller: computes result = x^e mod M.
- Acts as initiator on the start/done/in_a/in_b/in_m/result interface of the `montgomery` multiplier: it issues start pulses and consumes done/result.
- Uses left-to-right square-and-multiply over Montgomery products. Sits between the top-level RSA control and one `montgomery` instance.
- Caller supplies the precomputed values R mod M and R² mod M, where R = 2^N.

---
 rtl/montgomery_exp_pkg.sv | 30 +++
 rtl/montgomery_exp_bitsel.sv | 52 +++++
 rtl/montgomery_exp.sv | 157 +++++++++++++++
 tb/tb_montgomery_exp.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/montgomery_exp_pkg.sv
// Shared state encoding and default sizes for the Montgomery exponentiation controller.
`default_nettype none

package montgomery_exp_pkg;

  localparam int N_DEFAULT       = 1024;
  localparam int E_WIDTH_DEFAULT = 1024;

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    TOMONT_ISSUE = 4'd1,
    TOMONT_WAIT  = 4'd2,
    SCAN         = 4'd3,
    SQ_ISSUE     = 4'd4,
    SQ_WAIT      = 4'd5,
    MUL_ISSUE    = 4'd6,
    MUL_WAIT     = 4'd7,
    NEXT         = 4'd8,
    FROM_ISSUE   = 4'd9,
    FROM_WAIT    = 4'd10,
    DONE         = 4'd11
  } state_t;

  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/montgomery_exp_bitsel.sv
// Exponent holder with a down-counting bit index, walked MSB to LSB.
// MONTGOMERY_EXP_SKIP_ZEROS_EN adds a scan input that steps over leading zero bits.
`default_nettype none

module montgomery_exp_bitsel
  import montgomery_exp_pkg::*;
#(
  parameter int E_WIDTH = E_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [E_WIDTH-1:0] load_e,
  input  logic               dec,
`ifdef MONTGOMERY_EXP_SKIP_ZEROS_EN
  input  logic               scan,
`endif
  output logic               cur_bit,
  output logic               last_bit
);

  localparam int IW = idx_width(E_WIDTH);

  logic [E_WIDTH-1:0] e_q;
  logic [IW-1:0]      idx;
  logic               step;

`ifdef MONTGOMERY_EXP_SKIP_ZEROS_EN
  // A zero bit above bit 0 needs no squaring before the first one-bit.
  assign step = dec || (scan && !cur_bit && !last_bit);
`else
  assign step = dec;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      idx <= '0;
    end else if (load) begin
      e_q <= load_e;
      idx <= IW'(E_WIDTH - 1);
    end else if (step && (idx != '0)) begin
      idx <= idx - 1'b1;
    end
  end

  assign cur_bit  = e_q[idx];
  assign last_bit = (idx == '0);

endmodule

`default_nettype wire

// File: rtl/montgomery_exp.sv
// Left-to-right square-and-multiply controller driving an external Montgomery multiplier.
// MONTGOMERY_EXP_SKIP_ZEROS_EN skips leading zero exponent bits without issuing products.
`default_nettype none

module montgomery_exp
  import montgomery_exp_pkg::*;
#(
  parameter int N       = N_DEFAULT,
  parameter int E_WIDTH = E_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N-1:0]       in_x,
  input  logic [E_WIDTH-1:0] in_e,
  input  logic [N-1:0]       in_m,
  input  logic [N-1:0]       in_rmodm,
  input  logic [N-1:0]       in_r2modm,
  output logic [N-1:0]       result,
  output logic               done,
  output logic               busy,
  output logic               mm_start,
  output logic [N-1:0]       mm_a,
  output logic [N-1:0]       mm_b,
  output logic [N-1:0]       mm_m,
  input  logic [N-1:0]       mm_result,
  input  logic               mm_done
);

  localparam logic [N-1:0] ONE = N'(1);

  state_t     state;
  logic [N-1:0] x_q, rmodm_q, r2modm_q, xt, acc;
  logic       bit_load, bit_dec, cur_bit, last_bit;

  assign bit_load = (state == IDLE) && start;
  assign bit_dec  = (state == NEXT) && !last_bit;

  montgomery_exp_bitsel #(.E_WIDTH(E_WIDTH)) u_bitsel (
    .clk      (clk),
    .reset    (reset),
    .load     (bit_load),
    .load_e   (in_e),
    .dec      (bit_dec),
`ifdef MONTGOMERY_EXP_SKIP_ZEROS_EN
    .scan     (state == SCAN),
`endif
    .cur_bit  (cur_bit),
    .last_bit (last_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      x_q      <= '0;
      rmodm_q  <= '0;
      r2modm_q <= '0;
      xt       <= '0;
      acc      <= '0;
      result   <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      mm_start <= 1'b0;
      mm_a     <= '0;
      mm_b     <= '0;
      mm_m     <= '0;
    end else begin
      mm_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_q      <= in_x;
            rmodm_q  <= in_rmodm;
            r2modm_q <= in_r2modm;
            mm_m     <= in_m;
            busy     <= 1'b1;
            state    <= TOMONT_ISSUE;
          end
        end
        TOMONT_ISSUE: begin
          mm_a     <= x_q;
          mm_b     <= r2modm_q;
          mm_start <= 1'b1;
          acc      <= rmodm_q;
          state    <= TOMONT_WAIT;
        end
        TOMONT_WAIT: begin
          if (mm_done) begin
            xt <= mm_result;
`ifdef MONTGOMERY_EXP_SKIP_ZEROS_EN
            state <= SCAN;
`else
            state <= SQ_ISSUE;
`endif
          end
        end
`ifdef MONTGOMERY_EXP_SKIP_ZEROS_EN
        SCAN: begin
          // The bit selector steps the index itself while parked here.
          if (cur_bit)       state <= SQ_ISSUE;
          else if (last_bit) state <= FROM_ISSUE;
        end
`endif
        SQ_ISSUE: begin
          mm_a     <= acc;
          mm_b     <= acc;
          mm_start <= 1'b1;
          state    <= SQ_WAIT;
        end
        SQ_WAIT: begin
          if (mm_done) begin
            acc   <= mm_result;
            state <= cur_bit ? MUL_ISSUE : NEXT;
          end
        end
        MUL_ISSUE: begin
          mm_a     <= acc;
          mm_b     <= xt;
          mm_start <= 1'b1;
          state    <= MUL_WAIT;
        end
        MUL_WAIT: begin
          if (mm_done) begin
            acc   <= mm_result;
            state <= NEXT;
          end
        end
        NEXT: begin
          state <= last_bit ? FROM_ISSUE : SQ_ISSUE;
        end
        FROM_ISSUE: begin
          mm_a     <= acc;
          mm_b     <= ONE;
          mm_start <= 1'b1;
          state    <= FROM_WAIT;
        end
        FROM_WAIT: begin
          if (mm_done) begin
            acc    <= mm_result;
            result <= mm_result;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_montgomery_exp.sv
// Directed and random checks of montgomery_exp against x^e mod M, with a 5-cycle Montgomery multiplier model.
`default_nettype none

module tb_montgomery_exp;

  localparam int N  = 8;
  localparam int EW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [N-1:0]  in_x, in_m, in_rmodm, in_r2modm;
  logic [EW-1:0] in_e;
  logic [N-1:0]  result, mm_a, mm_b, mm_m, mm_result;
  logic          done, busy, mm_start, mm_done;

  logic          model_done = 1'b0;
  logic [N-1:0]  model_res  = '0;
  logic          inj_done   = 1'b0;
  int            mm_cnt     = 0;
  int            n_starts   = 0;
  int            pa = 0, pb = 0, pm = 0;

  int checks = 0;
  int errors = 0;

  assign mm_done   = model_done | inj_done;
  assign mm_result = inj_done ? 8'hAA : model_res;

  always #5 clk = ~clk;

  montgomery_exp #(.N(N), .E_WIDTH(EW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_x      (in_x),
    .in_e      (in_e),
    .in_m      (in_m),
    .in_rmodm  (in_rmodm),
    .in_r2modm (in_r2modm),
    .result    (result),
    .done      (done),
    .busy      (busy),
    .mm_start  (mm_start),
    .mm_a      (mm_a),
    .mm_b      (mm_b),
    .mm_m      (mm_m),
    .mm_result (mm_result),
    .mm_done   (mm_done)
  );

  // Montgomery product a*b*R^-1 mod m with R = 2^8, found by search.
  function automatic int mm_ref(input int a, input int b, input int m);
    if (m <= 0) return 0;
    for (int k = 0; k < m; k++)
      if (((k * 256) % m) == ((a * b) % m)) return k;
    return 0;
  endfunction

  function automatic int modexp(input int x, input int e, input int m);
    int r;
    r = 1 % m;
    for (int k = 0; k < e; k++) r = (r * x) % m;
    return r;
  endfunction

  function automatic int exp_mm(input int e);
    logic [EW-1:0] ev;
    int pop, msb;
    ev  = e[EW-1:0];
    pop = $countones(ev);
    msb = -1;
    for (int k = 0; k < EW; k++) if (ev[k]) msb = k;
`ifdef MONTGOMERY_EXP_SKIP_ZEROS_EN
    return (msb < 0) ? 2 : 2 + (msb + 1) + pop;
`else
    return 2 + EW + pop;
`endif
  endfunction

  // Multiplier model: samples start mid-cycle, answers five cycles later.
  always @(negedge clk) begin
    model_done <= 1'b0;
    if (mm_cnt != 0) begin
      if (mm_cnt == 1) begin
        model_done <= 1'b1;
        model_res  <= N'(mm_ref(pa, pb, pm));
      end
      mm_cnt <= mm_cnt - 1;
    end
    if (mm_start) begin
      pa       <= int'(mm_a);
      pb       <= int'(mm_b);
      pm       <= int'(mm_m);
      mm_cnt   <= 5;
      n_starts <= n_starts + 1;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at the negedge after start is sampled.
  task automatic launch(input int x, input int e, input int m);
    in_x      = N'(x);
    in_e      = EW'(e);
    in_m      = N'(m);
    in_rmodm  = N'(256 % m);
    in_r2modm = N'(((256 % m) * (256 % m)) % m);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic finish_run(input string tag, input int x, input int e, input int m, input int s0);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    check({tag, "_done_seen"}, int'(seen), 1);
    check({tag, "_result"}, int'(result), modexp(x, e, m));
    check({tag, "_mm_count"}, n_starts - s0, exp_mm(e));
    @(negedge clk);
    check({tag, "_done_width"}, int'(done), 0);
    check({tag, "_busy_after"}, int'(busy), 0);
  endtask

  task automatic full_run(input string tag, input int x, input int e, input int m);
    int s0;
    s0 = n_starts;
    launch(x, e, m);
    check({tag, "_busy"}, int'(busy), 1);
    finish_run(tag, x, e, m, s0);
  endtask

  task automatic wait_starts(input int target);
    for (int c = 0; c < 300 && n_starts < target; c++) @(negedge clk);
    check("wait_mm_start", int'(n_starts >= target), 1);
  endtask

  initial begin
    int s0, x, e, m;
    reset = 1'b1; start = 1'b0;
    in_x = '0; in_e = '0; in_m = '0; in_rmodm = '0; in_r2modm = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_result", int'(result), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_mm_start", int'(mm_start), 0);
    check("rst_mm_a", int'(mm_a), 0);
    check("rst_mm_b", int'(mm_b), 0);
    check("rst_mm_m", int'(mm_m), 0);

    full_run("x2e5", 2, 5, 13);
    check("x2e5_is6", int'(result), 6);
    full_run("e0", 2, 0, 13);
    check("e0_is1", int'(result), 1);

    // Second run starts in the cycle right after done.
    full_run("x7e1", 7, 1, 13);
    check("x7e1_is7", int'(result), 7);
    full_run("x3e15", 3, 15, 13);
    check("x3e15_is1", int'(result), 1);

    // Start pulse while a squaring is outstanding.
    s0 = n_starts;
    launch(2, 5, 13);
    wait_starts(s0 + 2);
    in_x = 8'd3; in_e = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_busy", int'(busy), 1);
    finish_run("busy_start", 2, 5, 13, s0);
    check("busy_start_is6", int'(result), 6);

    // Reset while the multiply product is outstanding.
    s0 = n_starts;
    launch(2, 5, 13);
`ifdef MONTGOMERY_EXP_SKIP_ZEROS_EN
    wait_starts(s0 + 3);
`else
    wait_starts(s0 + 4);
`endif
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_result", int'(result), 0);
    check("midrst_mm_a", int'(mm_a), 0);
    check("midrst_mm_m", int'(mm_m), 0);
    repeat (8) @(negedge clk);
    check("stale_result", int'(result), 0);
    check("stale_busy", int'(busy), 0);
    check("stale_done", int'(done), 0);
    check("stale_mm_start", int'(mm_start), 0);
    full_run("after_rst", 2, 5, 13);

    // Spurious multiplier completions in IDLE and in the issue cycle.
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    @(negedge clk);
    check("idle_done_result", int'(result), 6);
    check("idle_done_busy", int'(busy), 0);
    check("idle_done_done", int'(done), 0);
    check("idle_done_mm_start", int'(mm_start), 0);
    s0 = n_starts;
    launch(3, 6, 13);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    finish_run("issue_done", 3, 6, 13, s0);

    // Random odd moduli, bases and exponents.
    for (int r = 0; r < 10; r++) begin
      m = int'($urandom_range(3, 255)) | 1;
      x = int'($urandom_range(0, m - 1));
      e = int'($urandom_range(0, 15));
      full_run("rand", x, e, m);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
